// File: rtl/alu_issue_ctrl_pkg.sv
// Shared types and constants for the SIMD ALU issue controller.
package alu_issue_ctrl_pkg;

    localparam int unsigned MODE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic DT_INT   = 1'b0;
    localparam logic DT_FLOAT = 1'b1;

    localparam logic [MODE_W-1:0] MODE_ADD = 4'd0;
    localparam logic [MODE_W-1:0] MODE_SUB = 4'd1;
    localparam logic [MODE_W-1:0] MODE_MUL = 4'd2;
    localparam logic [MODE_W-1:0] MODE_DIV = 4'd3;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/alu_issue_ctrl_lat_counter.sv
// Loadable down-counter; done_c flags the last clock of the wait window.
module lat_counter #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         done_c
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign done_c = (count == W'(1));

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issues one command at a time to an ALU lane, waits out its latency and
// returns the captured result over a valid/ready response channel.
module alu_issue_ctrl
    import alu_issue_ctrl_pkg::*;
#(
    parameter int unsigned bw       = 32,
    parameter int unsigned INT_LAT  = 1,
    parameter int unsigned FP_LAT   = 7,
    parameter int unsigned FP_MODES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [MODE_W-1:0] cmd_mode,
    input  logic              cmd_dtype,
    input  logic [bw-1:0]     cmd_a,
    input  logic [bw-1:0]     cmd_b,
    output logic [bw-1:0]     alu_a,
    output logic [bw-1:0]     alu_b,
    output logic [MODE_W-1:0] alu_mode,
    output logic              alu_dtype,
    input  logic [bw-1:0]     alu_result,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [bw-1:0]     res_data,
    output logic              res_err,
    output logic              busy
);

    localparam int unsigned CNT_W   = $clog2(max_u(INT_LAT, FP_LAT)) + 1;
    localparam int unsigned MODE_XW = MODE_W + 1;
    localparam logic [MODE_XW-1:0] FP_MODES_X = MODE_XW'(FP_MODES);

    state_t             state;
    state_t             state_d;
    logic               launch;
    logic               reject;
    logic               capture;
    logic               cnt_load;
    logic [CNT_W-1:0]   cnt_val;
    logic               cnt_done_c;

    lat_counter #(.W(CNT_W)) u_lat_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_val),
        .en       (state == ST_WAIT),
        .done_c   (cnt_done_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d  = state;
        launch   = 1'b0;
        reject   = 1'b0;
        capture  = 1'b0;
        cnt_load = 1'b0;
        cnt_val  = CNT_W'(INT_LAT);
        case (state)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    if ((cmd_dtype == DT_FLOAT) && ({1'b0, cmd_mode} >= FP_MODES_X)) begin
                        reject  = 1'b1;
                        state_d = ST_RESP;
                    end else begin
                        launch   = 1'b1;
                        cnt_load = 1'b1;
                        cnt_val  = (cmd_dtype == DT_INT) ? CNT_W'(INT_LAT) : CNT_W'(FP_LAT);
                        state_d  = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_done_c) begin
                    capture = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (res_valid && res_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A rejected command sits one cycle in RESP before res_valid rises, matching
    // the minimum one-clock turnaround of a real launch.
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_err   <= 1'b0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_mode  <= '0;
            alu_dtype <= 1'b0;
        end else begin
            cmd_ready <= (state_d == ST_IDLE);
            busy      <= (state_d != ST_IDLE);
            res_valid <= capture || ((state == ST_RESP) && !(res_valid && res_ready));
            if (launch) begin
                alu_a     <= cmd_a;
                alu_b     <= cmd_b;
                alu_mode  <= cmd_mode;
                alu_dtype <= cmd_dtype;
            end
            if (reject) begin
                res_data <= '0;
                res_err  <= 1'b1;
            end else if (capture) begin
                res_data <= alu_result;
                res_err  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a latency-aware ALU lane model.
module tb_alu_issue_ctrl;
    import alu_issue_ctrl_pkg::*;

    localparam int unsigned BW       = 32;
    localparam int unsigned INT_LAT  = 1;
    localparam int unsigned FP_LAT   = 7;
    localparam int unsigned FP_MODES = 4;

    logic              clk;
    logic              rst;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [3:0]        cmd_mode;
    logic              cmd_dtype;
    logic [BW-1:0]     cmd_a;
    logic [BW-1:0]     cmd_b;
    logic [BW-1:0]     alu_a;
    logic [BW-1:0]     alu_b;
    logic [3:0]        alu_mode;
    logic              alu_dtype;
    logic [BW-1:0]     alu_result;
    logic              res_valid;
    logic              res_ready;
    logic [BW-1:0]     res_data;
    logic              res_err;
    logic              busy;

    int n_vec = 0;
    int n_err = 0;
    int age = 100;
    int acc_cnt = 0;

    alu_issue_ctrl #(
        .bw(BW), .INT_LAT(INT_LAT), .FP_LAT(FP_LAT), .FP_MODES(FP_MODES)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mode(cmd_mode),
        .cmd_dtype(cmd_dtype), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .alu_a(alu_a), .alu_b(alu_b), .alu_mode(alu_mode), .alu_dtype(alu_dtype),
        .alu_result(alu_result),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_err(res_err), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Lane model: result only becomes correct LAT-1 clocks after the launch edge.
    function automatic logic [BW-1:0] lane_fn(input logic [3:0] m, input logic dt,
                                              input logic [BW-1:0] a, input logic [BW-1:0] b);
        if (dt == DT_INT) begin
            case (m)
                MODE_ADD: return a + b;
                MODE_SUB: return a - b;
                MODE_MUL: return a * b;
                MODE_DIV: return (b != 0) ? a / b : '0;
                default:  return '0;
            endcase
        end
        if (m == MODE_ADD && a == 32'h3F80_0000 && b == 32'h4000_0000) return 32'h4040_0000;
        return 32'h7FC0_0000;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            age <= 100;
        end else if (cmd_valid && cmd_ready) begin
            age     <= 0;
            acc_cnt <= acc_cnt + 1;
        end else if (age < 100) begin
            age <= age + 1;
        end
    end

    assign alu_result = (age >= ((alu_dtype ? int'(FP_LAT) : int'(INT_LAT)) - 1))
                        ? lane_fn(alu_mode, alu_dtype, alu_a, alu_b) : 32'hDEAD_BEEF;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] m, input logic dt, input logic [BW-1:0] a,
                        input logic [BW-1:0] b);
        cmd_mode  = m;
        cmd_dtype = dt;
        cmd_a     = a;
        cmd_b     = b;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_resp(output int cyc);
        cyc = 0;
        while (!res_valid && cyc < 50) begin
            tick();
            cyc++;
        end
    endtask

    task automatic test_reset();
        logic seen;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        n_vec++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); end
        n_vec++; if ({res_valid, res_err, busy} !== 3'b000) begin n_err++; $display("FAIL reset_flags: got %b want 000", {res_valid, res_err, busy}); end
        n_vec++; if ({res_data, alu_a, alu_b, alu_mode, alu_dtype} !== '0) begin n_err++; $display("FAIL reset_data: got %h want 0", {res_data, alu_a, alu_b, alu_mode, alu_dtype}); end
        // abort a float op two clocks into its wait
        send(4'd0, DT_FLOAT, 32'h1111_1111, 32'h2222_2222);
        tick();
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL midwait_busy: got %b want 1", busy); end
        rst = 1'b1;
        tick(); tick(); tick();
        rst = 1'b0;
        n_vec++; if ({cmd_ready, res_valid, res_err, busy} !== 4'b1000) begin n_err++; $display("FAIL abort_flags: got %b want 1000", {cmd_ready, res_valid, res_err, busy}); end
        n_vec++; if ({res_data, alu_a, alu_b, alu_mode, alu_dtype} !== '0) begin n_err++; $display("FAIL abort_data: got %h want 0", {res_data, alu_a, alu_b, alu_mode, alu_dtype}); end
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (res_valid !== 1'b0 || cmd_ready !== 1'b1) seen = 1'b1;
            tick();
        end
        n_vec++; if (seen !== 1'b0) begin n_err++; $display("FAIL abort_no_resp: got %b want 0", seen); end
    endtask

    task automatic test_int_add();
        int cyc;
        send(4'd0, DT_INT, 32'd5, 32'd7);
        wait_resp(cyc);
        n_vec++; if (cyc !== int'(INT_LAT)) begin n_err++; $display("FAIL int_latency: got %0d want %0d", cyc, INT_LAT); end
        n_vec++; if (res_data !== 32'd12) begin n_err++; $display("FAIL int_add_data: got %h want 0000000c", res_data); end
        n_vec++; if (res_err !== 1'b0) begin n_err++; $display("FAIL int_add_err: got %b want 0", res_err); end
        tick();
        n_vec++; if ({res_valid, cmd_ready, busy} !== 3'b010) begin n_err++; $display("FAIL int_done: got %b want 010", {res_valid, cmd_ready, busy}); end
    endtask

    task automatic test_float_add();
        int   cyc;
        logic stable;
        send(4'd0, DT_FLOAT, 32'h3F80_0000, 32'h4000_0000);
        cyc    = 0;
        stable = 1'b1;
        while (!res_valid && cyc < 50) begin
            if (alu_a !== 32'h3F80_0000 || alu_b !== 32'h4000_0000) stable = 1'b0;
            tick();
            cyc++;
        end
        n_vec++; if (cyc !== int'(FP_LAT)) begin n_err++; $display("FAIL fp_latency: got %0d want %0d", cyc, FP_LAT); end
        n_vec++; if (stable !== 1'b1) begin n_err++; $display("FAIL fp_operands_stable: got %b want 1", stable); end
        n_vec++; if (res_data !== 32'h4040_0000) begin n_err++; $display("FAIL fp_add_data: got %h want 40400000", res_data); end
        n_vec++; if (res_err !== 1'b0) begin n_err++; $display("FAIL fp_add_err: got %b want 0", res_err); end
        tick();
        n_vec++; if ({res_valid, cmd_ready} !== 2'b01) begin n_err++; $display("FAIL fp_done: got %b want 01", {res_valid, cmd_ready}); end
    endtask

    task automatic test_illegal_float();
        int cyc;
        send(4'd5, DT_FLOAT, 32'h1234_5678, 32'h9ABC_DEF0);
        n_vec++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL illegal_early_valid: got %b want 0", res_valid); end
        wait_resp(cyc);
        n_vec++; if (cyc !== 1) begin n_err++; $display("FAIL illegal_latency: got %0d want 1", cyc); end
        n_vec++; if ({res_err, res_data} !== {1'b1, 32'h0}) begin n_err++; $display("FAIL illegal_resp: got %h want 100000000", {res_err, res_data}); end
        n_vec++; if ({alu_a, alu_b, alu_mode, alu_dtype} !== {32'h3F80_0000, 32'h4000_0000, 4'd0, 1'b1}) begin
            n_err++; $display("FAIL illegal_alu_held: got %h want %h", {alu_a, alu_b, alu_mode, alu_dtype}, {32'h3F80_0000, 32'h4000_0000, 4'd0, 1'b1});
        end
        tick();
        n_vec++; if ({res_valid, cmd_ready} !== 2'b01) begin n_err++; $display("FAIL illegal_done: got %b want 01", {res_valid, cmd_ready}); end
    endtask

    task automatic test_backpressure();
        int   cyc;
        int   a0;
        logic held;
        res_ready = 1'b0;
        send(4'd1, DT_INT, 32'd20, 32'd3);
        wait_resp(cyc);
        n_vec++; if (res_data !== 32'd17) begin n_err++; $display("FAIL bp_data: got %h want 00000011", res_data); end
        a0   = acc_cnt;
        held = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cmd_valid = i[0];
            cmd_a     = 32'hAAAA_0000 + 32'(i);
            cmd_mode  = 4'd2;
            cmd_dtype = DT_INT;
            tick();
            if (res_valid !== 1'b1 || res_data !== 32'd17 || cmd_ready !== 1'b0 || alu_a !== 32'd20) held = 1'b0;
        end
        cmd_valid = 1'b0;
        n_vec++; if (held !== 1'b1) begin n_err++; $display("FAIL bp_hold: got %b want 1", held); end
        n_vec++; if (acc_cnt - a0 !== 0) begin n_err++; $display("FAIL bp_ignored_cmds: got %0d want 0", acc_cnt - a0); end
        res_ready = 1'b1;
        tick();
        n_vec++; if ({res_valid, cmd_ready} !== 2'b01) begin n_err++; $display("FAIL bp_release: got %b want 01", {res_valid, cmd_ready}); end
        send(4'd2, DT_INT, 32'd9, 32'd11);
        wait_resp(cyc);
        n_vec++; if (res_data !== 32'd99) begin n_err++; $display("FAIL bp_next_cmd: got %h want 00000063", res_data); end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [3:0]    vm [4];
        logic [BW-1:0] va [4];
        logic [BW-1:0] vb [4];
        logic [BW-1:0] vr [4];
        int            cyc;
        int            k;
        int            a0;
        vm = '{4'd0, 4'd1, 4'd2, 4'd3};
        va = '{32'd100, 32'd50, 32'd6, 32'd100};
        vb = '{32'd23, 32'd8, 32'd7, 32'd7};
        vr = '{32'd123, 32'd42, 32'd42, 32'd14};
        res_ready = 1'b1;
        a0        = acc_cnt;
        cmd_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cmd_mode  = vm[i];
            cmd_dtype = DT_INT;
            cmd_a     = va[i];
            cmd_b     = vb[i];
            k = 0;
            while (!cmd_ready && k < 50) begin
                tick();
                k++;
            end
            tick();
            if (i == 3) cmd_valid = 1'b0;
            wait_resp(cyc);
            n_vec++; if (res_data !== vr[i]) begin n_err++; $display("FAIL b2b_data_%0d: got %h want %h", i, res_data, vr[i]); end
        end
        tick();
        n_vec++; if (acc_cnt - a0 !== 4) begin n_err++; $display("FAIL b2b_accepts: got %0d want 4", acc_cnt - a0); end
        n_vec++; if ({res_valid, cmd_ready, busy} !== 3'b010) begin n_err++; $display("FAIL b2b_idle: got %b want 010", {res_valid, cmd_ready, busy}); end
    endtask

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_mode  = '0;
        cmd_dtype = 1'b0;
        cmd_a     = '0;
        cmd_b     = '0;
        res_ready = 1'b1;
        #1;
        test_reset();
        test_int_add();
        test_float_add();
        test_illegal_float();
        test_backpressure();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
